// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - forwarding select and load-use stall control for the 5-stage core
//
// Purpose
//   Keeps a shadow pipeline of destination tags {valid, rd, is_load} for the
//   instructions in EX, ME and WB. From the ID-stage operands it computes
//   the EX operand-mux selects and registers them as the instruction advances
//   from ID to EX. It also raises a combinational load-use stall request when
//   the value a load produces cannot be forwarded in time.
//
// Optional feature
//   LOAD_USE_PERF_EN : when defined, adds output perf_lu_cnt and a wrapping
//                      counter of load-use stall cycles that really took
//                      effect. When undefined, the port and counter are absent.
//
// Ports
//   clock           in   1           core clock, rising edge
//   reset_n         in   1           asynchronous active-low reset
//   stall_i         in   1           global freeze; all state holds
//   flush_i         in   1           kills the ID-stage instruction
//   id_valid        in   1           ID holds a real instruction
//   id_rs1_ren      in   1           ID reads rs1
//   id_rs1_addr     in   REG_AW      ID rs1 index
//   id_rs2_ren      in   1           ID reads rs2
//   id_rs2_addr     in   REG_AW      ID rs2 index
//   id_rd_wen       in   1           ID writes rd
//   id_rd_addr      in   REG_AW      ID rd index
//   id_is_load      in   1           ID instruction is a load
//   ex_rs1_src      out  2           EX rs1 mux select (registered)
//   ex_rs2_src      out  2           EX rs2 mux select (registered)
//   load_use_stall  out  1           combinational stall request
//   perf_lu_cnt     out  PERF_CNT_W  load-use stall cycles (optional)

`ifndef RS1_EX
`define RS1_EX 2'b00
`endif
`ifndef RS1_ME
`define RS1_ME 2'b01
`endif
`ifndef RS1_WB
`define RS1_WB 2'b10
`endif

module fwd_ctrl #(
  parameter int REG_AW     = 5
`ifdef LOAD_USE_PERF_EN
  ,
  parameter int PERF_CNT_W = 32
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic              id_rs1_ren,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic              id_rs2_ren,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rd_wen,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_is_load,
  output logic [1:0]        ex_rs1_src,
  output logic [1:0]        ex_rs2_src,
  output logic              load_use_stall
`ifdef LOAD_USE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_lu_cnt
`endif
);

  localparam logic [REG_AW-1:0] X0 = '0;

  // Shadow tag pipeline
  logic              ex_valid_q, me_valid_q, wb_valid_q;
  logic [REG_AW-1:0] ex_rd_q,    me_rd_q,    wb_rd_q;
  logic              ex_load_q,  me_load_q,  wb_load_q;

  // Registered operand selects seen by the EX stage
  logic [1:0] rs1_src_q, rs2_src_q;

  // Next-state values
  logic              ex_valid_d;
  logic [REG_AW-1:0] ex_rd_d;
  logic              ex_load_d;
  logic [1:0]        rs1_src_d, rs2_src_d;

  // Operand match terms
  logic rs1_live, rs2_live;
  logic rs1_ex_hit, rs2_ex_hit;
  logic rs1_me_hit, rs2_me_hit;
  logic [1:0] rs1_sel, rs2_sel;
  logic lu_hazard;
  logic bubble;

  always_comb begin
    // An operand only needs forwarding if it is really read and is not x0.
    rs1_live   = id_rs1_ren && (id_rs1_addr != X0);
    rs2_live   = id_rs2_ren && (id_rs2_addr != X0);

    // Tags are only ever valid for rd != x0, so x0 can never match here.
    rs1_ex_hit = rs1_live && ex_valid_q && (ex_rd_q == id_rs1_addr);
    rs2_ex_hit = rs2_live && ex_valid_q && (ex_rd_q == id_rs2_addr);
    rs1_me_hit = rs1_live && me_valid_q && (me_rd_q == id_rs1_addr);
    rs2_me_hit = rs2_live && me_valid_q && (me_rd_q == id_rs2_addr);

    // The producer now in EX will sit in ME when this instruction reaches EX,
    // and one now in ME will sit in WB. The EX hit is tested first so the
    // youngest producer wins when both match.
    if (rs1_ex_hit)      rs1_sel = `RS1_ME;
    else if (rs1_me_hit) rs1_sel = `RS1_WB;
    else                 rs1_sel = `RS1_EX;

    if (rs2_ex_hit)      rs2_sel = `RS1_ME;
    else if (rs2_me_hit) rs2_sel = `RS1_WB;
    else                 rs2_sel = `RS1_EX;

    // A load in EX has no data until the end of ME, so a consumer right
    // behind it must wait one cycle. A flushed ID instruction is dead and
    // never stalls.
    lu_hazard = id_valid && !flush_i && ex_valid_q && ex_load_q &&
                (rs1_ex_hit || rs2_ex_hit);

    bubble    = lu_hazard || flush_i || !id_valid;

    // Next EX tag and selects: a bubble enters EX as an invalid tag with
    // neutral selects.
    ex_valid_d = !bubble && id_rd_wen && (id_rd_addr != X0);
    ex_rd_d    = bubble ? X0   : id_rd_addr;
    ex_load_d  = !bubble && id_is_load;
    rs1_src_d  = bubble ? `RS1_EX : rs1_sel;
    rs2_src_d  = bubble ? `RS1_EX : rs2_sel;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= X0;
      ex_load_q  <= 1'b0;
      me_valid_q <= 1'b0;
      me_rd_q    <= X0;
      me_load_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= X0;
      wb_load_q  <= 1'b0;
      rs1_src_q  <= `RS1_EX;
      rs2_src_q  <= `RS1_EX;
    end else if (!stall_i) begin
      wb_valid_q <= me_valid_q;
      wb_rd_q    <= me_rd_q;
      wb_load_q  <= me_load_q;
      me_valid_q <= ex_valid_q;
      me_rd_q    <= ex_rd_q;
      me_load_q  <= ex_load_q;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_load_q  <= ex_load_d;
      rs1_src_q  <= rs1_src_d;
      rs2_src_q  <= rs2_src_d;
    end
  end

  // The WB tag completes the shadow pipeline but drives no select: an ID
  // operand matching WB reads the value through the register-file
  // write-through path.
  logic wb_tag_unused;
  assign wb_tag_unused = ^{wb_valid_q, wb_rd_q, wb_load_q};

  assign ex_rs1_src     = rs1_src_q;
  assign ex_rs2_src     = rs2_src_q;
  assign load_use_stall = lu_hazard;

`ifdef LOAD_USE_PERF_EN
  // Count only stall cycles that really took effect. A frozen pipeline
  // re-evaluates the hazard after release, so frozen cycles are not counted.
  logic [PERF_CNT_W-1:0] perf_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt_q <= '0;
    end else if (lu_hazard && !stall_i) begin
      perf_cnt_q <= perf_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign perf_lu_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - directed-vector bench for fwd_ctrl
module tb_fwd_ctrl;

  localparam logic [1:0] SRC_EX = 2'd0;
  localparam logic [1:0] SRC_ME = 2'd1;
  localparam logic [1:0] SRC_WB = 2'd2;

  logic       clock;
  logic       reset_n;
  logic       stall_i;
  logic       flush_i;
  logic       id_valid;
  logic       id_rs1_ren;
  logic [4:0] id_rs1_addr;
  logic       id_rs2_ren;
  logic [4:0] id_rs2_addr;
  logic       id_rd_wen;
  logic [4:0] id_rd_addr;
  logic       id_is_load;
  logic [1:0] ex_rs1_src;
  logic [1:0] ex_rs2_src;
  logic       load_use_stall;
`ifdef LOAD_USE_PERF_EN
  logic [31:0] perf_lu_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_perf = 0;

  fwd_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .id_valid       (id_valid),
    .id_rs1_ren     (id_rs1_ren),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_ren     (id_rs2_ren),
    .id_rs2_addr    (id_rs2_addr),
    .id_rd_wen      (id_rd_wen),
    .id_rd_addr     (id_rd_addr),
    .id_is_load     (id_is_load),
    .ex_rs1_src     (ex_rs1_src),
    .ex_rs2_src     (ex_rs2_src),
    .load_use_stall (load_use_stall)
`ifdef LOAD_USE_PERF_EN
    ,
    .perf_lu_cnt    (perf_lu_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic r1en, input logic [4:0] r1,
                        input logic r2en, input logic [4:0] r2,
                        input logic wen, input logic [4:0] rd, input logic ld);
    id_valid    = v;
    id_rs1_ren  = r1en;
    id_rs1_addr = r1;
    id_rs2_ren  = r2en;
    id_rs2_addr = r2;
    id_rd_wen   = wen;
    id_rd_addr  = rd;
    id_is_load  = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic check_perf(input string tag);
`ifdef LOAD_USE_PERF_EN
    check_vec(tag, perf_lu_cnt, exp_perf);
`else
    if (tag.len() == 0) vec_cnt = vec_cnt;
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    nop();
    #2;
    check_vec("rst_rs1", ex_rs1_src, SRC_EX);
    check_vec("rst_rs2", ex_rs2_src, SRC_EX);
    check_vec("rst_lus", load_use_stall, 1'b0);
    check_perf("rst_perf");
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check_vec("nop_rs1", ex_rs1_src, SRC_EX);
    check_vec("nop_rs2", ex_rs2_src, SRC_EX);

    // add x5,x1,x2 ; add x6,x5,x5
    set_id(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0);
    tick();
    set_id(1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0);
    #1;
    check_vec("exfwd_lus", load_use_stall, 1'b0);
    tick();
    check_vec("exfwd_rs1", ex_rs1_src, SRC_ME);
    check_vec("exfwd_rs2", ex_rs2_src, SRC_ME);

    // add x5 ; nop ; sub x7,x5,x1
    drain();
    set_id(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0);
    tick();
    nop();
    tick();
    set_id(1, 1, 5'd5, 1, 5'd1, 1, 5'd7, 0);
    #1;
    check_vec("mefwd_lus", load_use_stall, 1'b0);
    tick();
    check_vec("mefwd_rs1", ex_rs1_src, SRC_WB);
    check_vec("mefwd_rs2", ex_rs2_src, SRC_EX);

    // add x5 ; nop ; nop ; read x5 -> WB match left to regfile
    drain();
    set_id(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0);
    tick();
    nop();
    repeat (2) tick();
    set_id(1, 1, 5'd5, 0, 5'd0, 1, 5'd8, 0);
    tick();
    check_vec("wbdist_rs1", ex_rs1_src, SRC_EX);

    // add x5 ; consumer with rs1_ren=0 naming x5 -> no forward
    drain();
    set_id(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0);
    tick();
    set_id(1, 0, 5'd5, 1, 5'd3, 1, 5'd9, 0);
    tick();
    check_vec("noren_rs1", ex_rs1_src, SRC_EX);

    // lw x5 ; add x6,x5,x0 -> one stall cycle
    drain();
    set_id(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1);
    tick();
    set_id(1, 1, 5'd5, 1, 5'd0, 1, 5'd6, 0);
    #1;
    check_vec("lu_stall", load_use_stall, 1'b1);
    tick();
    exp_perf++;
    check_vec("lu_bub_rs1", ex_rs1_src, SRC_EX);
    check_vec("lu_release", load_use_stall, 1'b0);
    check_perf("lu_perf");
    tick();
    check_vec("lu_add_rs1", ex_rs1_src, SRC_WB);
    check_vec("lu_add_rs2", ex_rs2_src, SRC_EX);

    // lw x5 ; instruction not reading x5 -> no stall
    drain();
    set_id(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1);
    tick();
    set_id(1, 0, 5'd5, 1, 5'd3, 1, 5'd6, 0);
    #1;
    check_vec("lu_noren", load_use_stall, 1'b0);

    // add x0 ; add x1,x0,x0 -> x0 never forwarded
    drain();
    set_id(1, 1, 5'd1, 1, 5'd2, 1, 5'd0, 0);
    tick();
    set_id(1, 1, 5'd0, 1, 5'd0, 1, 5'd1, 0);
    tick();
    check_vec("x0_rs1", ex_rs1_src, SRC_EX);
    check_vec("x0_rs2", ex_rs2_src, SRC_EX);

    // lw x0 ; read x0 -> no stall
    drain();
    set_id(1, 1, 5'd1, 0, 5'd0, 1, 5'd0, 1);
    tick();
    set_id(1, 1, 5'd0, 1, 5'd0, 1, 5'd6, 0);
    #1;
    check_vec("x0_lus", load_use_stall, 1'b0);

    // add x5 ; add x5 ; add x6,x5,x9 -> youngest wins
    drain();
    set_id(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0);
    tick();
    set_id(1, 1, 5'd2, 1, 5'd3, 1, 5'd5, 0);
    tick();
    set_id(1, 1, 5'd5, 1, 5'd9, 1, 5'd6, 0);
    tick();
    check_vec("prio_rs1", ex_rs1_src, SRC_ME);
    check_vec("prio_rs2", ex_rs2_src, SRC_EX);

    // add x1 ; lw x5,(x1) ; add x6,x5,x0 with 3-cycle freeze
    drain();
    set_id(1, 1, 5'd2, 1, 5'd3, 1, 5'd1, 0);
    tick();
    set_id(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1);
    tick();
    check_vec("stl_lw_rs1", ex_rs1_src, SRC_ME);
    set_id(1, 1, 5'd5, 1, 5'd0, 1, 5'd6, 0);
    stall_i = 1'b1;
    #1;
    check_vec("stl_lus0", load_use_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("stl_hold_rs1", ex_rs1_src, SRC_ME);
      check_vec("stl_hold_lus", load_use_stall, 1'b1);
    end
    check_perf("stl_perf_hold");
    stall_i = 1'b0;
    tick();
    exp_perf++;
    check_vec("stl_bub_rs1", ex_rs1_src, SRC_EX);
    check_vec("stl_rel_lus", load_use_stall, 1'b0);
    check_perf("stl_perf");
    tick();
    check_vec("stl_add_rs1", ex_rs1_src, SRC_WB);

    // lw x5 ; flushed add x6,x5,x0 ; add x7,x6,x5
    drain();
    set_id(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1);
    tick();
    set_id(1, 1, 5'd5, 1, 5'd0, 1, 5'd6, 0);
    flush_i = 1'b1;
    #1;
    check_vec("fl_lus", load_use_stall, 1'b0);
    tick();
    flush_i = 1'b0;
    set_id(1, 1, 5'd6, 1, 5'd5, 1, 5'd7, 0);
    #1;
    check_vec("fl_next_lus", load_use_stall, 1'b0);
    tick();
    check_vec("fl_bub_rs1", ex_rs1_src, SRC_EX);
    check_vec("fl_me_rs2", ex_rs2_src, SRC_WB);
    check_perf("fl_perf");

    // Reset mid-stream with a pending load-use and forwarded selects
    drain();
    set_id(1, 1, 5'd2, 1, 5'd3, 1, 5'd1, 0);
    tick();
    set_id(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1);
    tick();
    set_id(1, 1, 5'd5, 1, 5'd0, 1, 5'd6, 0);
    #1;
    check_vec("mrst_pre_lus", load_use_stall, 1'b1);
    reset_n = 1'b0;
    #1;
    exp_perf = 0;
    check_vec("mrst_lus", load_use_stall, 1'b0);
    check_vec("mrst_rs1", ex_rs1_src, SRC_EX);
    check_vec("mrst_rs2", ex_rs2_src, SRC_EX);
    check_perf("mrst_perf");
    tick();
    reset_n = 1'b1;
    nop();
    repeat (2) tick();
    check_vec("mrst_nop_rs1", ex_rs1_src, SRC_EX);
    check_vec("mrst_nop_rs2", ex_rs2_src, SRC_EX);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
